// File: rtl/data_mem_responder.sv
// Data memory for the 16-bit datapath: load/store with WAIT_CYCLES wait states and a ready pulse.
// Optional per-word even parity with error injection when DMEM_PARITY_EN is defined.
module data_mem_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_read,
  input  logic              mem_write,
`ifdef DMEM_PARITY_EN
  input  logic              parity_inject,
`endif
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthL = DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic              in_range, conflict, is_load, access, do_write, parity_err;

  assign idx      = addr_q[IDX_W-1:0];
  assign rd_word  = mem[idx];
  assign in_range = {1'b0, addr_q} < DepthL;
  assign conflict = read_q & write_q;
  assign is_load  = read_q & ~write_q & in_range;
  assign do_write = access & write_q & ~read_q & in_range;

`ifdef DMEM_PARITY_EN
  logic par_mem [DEPTH];
  logic pinj_q, pinj_d;

  assign parity_err = is_load & ((^rd_word) != par_mem[idx]);

  always_ff @(posedge clk) begin
    if (do_write) par_mem[idx] <= (^wdata_q) ^ pinj_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pinj_q <= 1'b0;
    else     pinj_q <= pinj_d;
  end

  always_comb begin
    pinj_d = pinj_q;
    if (state_q == StIdle && (mem_read || mem_write)) pinj_d = parity_inject;
  end
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    read_d  = read_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    access  = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_read || mem_write) begin
          state_d = StWait;
          cnt_d   = 4'(WAIT_CYCLES);
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          read_d  = mem_read;
          write_d = mem_write;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          // Access edge: the response is registered here and presented in StResp.
          access  = 1'b1;
          state_d = StResp;
          rdata_d = is_load ? rd_word : '0;
          err_d   = conflict | ~in_range | parity_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_ready = (state_q == StResp);
  assign mem_rdata = mem_ready ? rdata_q : '0;
  assign mem_err   = mem_ready & err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH=2048, WAIT_CYCLES=2) with a per-cycle model check.
module tb_data_mem_responder;

  localparam int unsigned W     = 2;
  localparam int unsigned DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        parity_inject = 1'b0;
  logic [15:0] mem_rdata;
  logic        mem_ready, mem_err, busy;

  data_mem_responder #(
    .ADDR_W(12), .DATA_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
`ifdef DMEM_PARITY_EN
    .parity_inject(parity_inject),
`endif
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_err  (mem_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: word contents and parity written so far, plus the one request in flight.
  logic [15:0] model_mem [int];
  logic        model_par [int];
  bit          m_active = 1'b0;
  int          acc_cyc = 0;
  logic [15:0] m_rdata;
  logic        m_err;

  always @(negedge clk) begin
    logic e_busy, e_ready;
    e_busy  = 1'b0;
    e_ready = 1'b0;
    if (!rst && m_active) begin
      e_busy  = (cyc >= acc_cyc) && (cyc <= acc_cyc + W + 1);
      e_ready = (cyc == acc_cyc + W + 1);
    end
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("ready", {31'd0, mem_ready}, {31'd0, e_ready});
    chk("rdata", {16'd0, mem_rdata}, e_ready ? {16'd0, m_rdata} : 32'd0);
    chk("err", {31'd0, mem_err}, e_ready ? {31'd0, m_err} : 32'd0);
  end

  logic [15:0] got_rdata;
  logic        got_err;
  int          got_lat, busy_cnt;

  task automatic do_req(input logic rd, input logic wr, input logic [11:0] a,
                        input logic [15:0] d, input logic inj, input bit scramble);
    bit   got_ready, bad, wr_ok;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = d; parity_inject = inj;
    bad   = (rd && wr) || (a >= DEPTH);
    wr_ok = wr && !bad;
    m_rdata = (!bad && rd) ? model_mem[int'(a)] : 16'h0;
    m_err   = bad;
`ifdef DMEM_PARITY_EN
    if (!bad && rd) m_err = (^model_mem[int'(a)]) != model_par[int'(a)];
`endif
    @(posedge clk); #1;
    acc_cyc = cyc; m_active = 1'b1;
    got_ready = 1'b0; busy_cnt = 0; got_lat = -1; got_rdata = 'x; got_err = 'x;
    for (int i = 0; i < 40 && !got_ready; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (mem_ready) begin
        got_ready = 1'b1; got_rdata = mem_rdata; got_err = mem_err; got_lat = cyc - acc_cyc;
      end else if (scramble) begin
        mem_addr = 12'($urandom); mem_wdata = 16'($urandom);
      end
    end
    if (!got_ready) chk("ready_timeout", 32'd0, 32'd1);
    if (wr_ok) begin
      model_mem[int'(a)] = d;
      model_par[int'(a)] = (^d) ^ inj;
    end
    // Strobes held through the ready cycle, dropped after the next edge.
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; parity_inject = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_req(0, 1, 12'h010, 16'hBEEF, 0, 0);
    chk("st_lat", got_lat, 3);
    chk("st_err", {31'd0, got_err}, 0);
    do_req(1, 0, 12'h010, 16'h0000, 0, 0);
    chk("ld_lat", got_lat, 3);
    chk("ld_data", {16'd0, got_rdata}, 32'hBEEF);
    chk("ld_err", {31'd0, got_err}, 0);

    do_req(1, 0, 12'h010, 16'h0000, 0, 1);
    chk("scr_data", {16'd0, got_rdata}, 32'hBEEF);
    chk("scr_busy", busy_cnt, W + 2);

    do_req(0, 1, 12'h020, 16'h1234, 0, 0);
    do_req(1, 1, 12'h020, 16'hFFFF, 0, 0);
    chk("rw_err", {31'd0, got_err}, 1);
    chk("rw_data", {16'd0, got_rdata}, 0);
    do_req(1, 0, 12'h020, 16'h0000, 0, 0);
    chk("rw_keep", {16'd0, got_rdata}, 32'h1234);

    do_req(0, 1, 12'h000, 16'h0C0C, 0, 0);
    do_req(1, 0, 12'h800, 16'h0000, 0, 0);
    chk("oor_ld_err", {31'd0, got_err}, 1);
    chk("oor_ld_data", {16'd0, got_rdata}, 0);
    do_req(0, 1, 12'h800, 16'hAAAA, 0, 0);
    chk("oor_st_err", {31'd0, got_err}, 1);
    do_req(1, 0, 12'h000, 16'h0000, 0, 0);
    chk("oor_alias", {16'd0, got_rdata}, 32'h0C0C);
    do_req(1, 0, 12'hFFF, 16'h0000, 0, 0);
    chk("oor_top_err", {31'd0, got_err}, 1);

    // Reset while the counter holds 1: the store must not land and no ready may follow.
    do_req(0, 1, 12'h030, 16'h0A0A, 0, 0);
    @(negedge clk);
    mem_write = 1'b1; mem_addr = 12'h030; mem_wdata = 16'h5555;
    m_rdata = 16'h0; m_err = 1'b0;
    @(posedge clk); #1;
    acc_cyc = cyc; m_active = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; m_active = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    @(posedge clk); #1;
    mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    do_req(1, 0, 12'h030, 16'h0000, 0, 0);
    chk("abort_keep", {16'd0, got_rdata}, 32'h0A0A);
    chk("abort_err", {31'd0, got_err}, 0);

`ifdef DMEM_PARITY_EN
    do_req(0, 1, 12'h040, 16'h0001, 1, 0);
    do_req(1, 0, 12'h040, 16'h0000, 0, 0);
    chk("par_inj_data", {16'd0, got_rdata}, 32'h0001);
    chk("par_inj_err", {31'd0, got_err}, 1);
    do_req(0, 1, 12'h040, 16'h0001, 0, 0);
    do_req(1, 0, 12'h040, 16'h0000, 0, 0);
    chk("par_ok_err", {31'd0, got_err}, 0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
